// File: rtl/addsub_result_collector_if.sv
// Handshake bundle between the upstream adder/subtractor, the result collector and its consumer.
//   in_valid/in_result/in_overflow : upstream result capture (no backpressure)
//   out_valid/out_ready            : consumer handshake for the FIFO head entry
//   out_result/out_overflow        : FIFO head entry data
// master: the side that produces results and consumes the head entry.
// slave : the collector itself.
interface addsub_result_collector_if #(
  parameter int unsigned DATAWIDTH = 8
);
  logic                 in_valid;
  logic [DATAWIDTH-1:0] in_result;
  logic                 in_overflow;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_result;
  logic                 out_overflow;

  modport master (
    output in_valid,
    output in_result,
    output in_overflow,
    output out_ready,
    input  out_valid,
    input  out_result,
    input  out_overflow
  );

  modport slave (
    input  in_valid,
    input  in_result,
    input  in_overflow,
    input  out_ready,
    output out_valid,
    output out_result,
    output out_overflow
  );
endinterface

// File: rtl/addsub_result_collector.sv
// Result collector: queues each upstream Result/Overflow pair in a small first-word-fall-through
// FIFO and hands it to a consumer over valid/ready. Results arriving while full (with no
// same-cycle pop) are dropped and counted; accepted overflow results are counted too.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   bus          : slave side of the handshake bundle (capture in, head entry out)
//   i_clear      : synchronous pulse zeroing both statistics counters
//   o_count      : occupancy 0..DEPTH
//   o_full       : occupancy == DEPTH
//   o_empty      : occupancy == 0
//   o_drop_count : saturating count of dropped results
//   o_ovf_count  : saturating count of accepted results with overflow set
module addsub_result_collector #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNTWIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  addsub_result_collector_if.slave  bus,
  input  logic                      i_clear,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [CNTWIDTH-1:0]       o_drop_count,
  output logic [CNTWIDTH-1:0]       o_ovf_count
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Each entry is {overflow, result}.
  logic [DATAWIDTH:0]  r_mem [DEPTH];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]     r_count;
  logic [CntW-1:0]     w_count_nxt;
  logic [CNTWIDTH-1:0] r_drop_cnt;
  logic [CNTWIDTH-1:0] r_ovf_cnt;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == CntW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push  = bus.in_valid && (!w_full || w_pop);
  assign w_drop  = bus.in_valid && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CntW'(1);
      2'b01:   w_count_nxt = r_count - CntW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Memory is reset so the stale head reads as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_overflow, bus.in_result};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= w_count_nxt;
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
      r_ovf_cnt  <= '0;
    end else if (i_clear) begin
      r_drop_cnt <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNTWIDTH'(1);
      if (w_push && bus.in_overflow && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + CNTWIDTH'(1);
    end
  end

  assign bus.out_valid    = !w_empty;
  assign bus.out_result   = r_mem[r_rd_ptr][DATAWIDTH-1:0];
  assign bus.out_overflow = r_mem[r_rd_ptr][DATAWIDTH];

  assign o_count      = r_count;
  assign o_full       = w_full;
  assign o_empty      = w_empty;
  assign o_drop_count = r_drop_cnt;
  assign o_ovf_count  = r_ovf_cnt;
endmodule

// File: tb/tb_addsub_result_collector.sv
module tb_addsub_result_collector;
  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic [7:0] drop_count;
  logic [7:0] ovf_count;

  int checks;
  int failures;

  addsub_result_collector_if #(.DATAWIDTH(8)) bus_if ();

  addsub_result_collector #(
    .DATAWIDTH(8),
    .DEPTH    (4),
    .CNTWIDTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .i_clear     (clear),
    .o_count     (count),
    .o_full      (full),
    .o_empty     (empty),
    .o_drop_count(drop_count),
    .o_ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] ir;
    logic       io;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] er;
    logic       eo;
    logic [2:0] ec;
    logic [7:0] ed;
    logic [7:0] eov;
  } vec_t;

  function automatic vec_t mk(int iv, int ir, int io, int rdy, int clr,
                              int ev, int er, int eo, int ec, int ed, int eov);
    vec_t v;
    v.iv  = iv[0];
    v.ir  = ir[7:0];
    v.io  = io[0];
    v.rdy = rdy[0];
    v.clr = clr[0];
    v.ev  = ev[0];
    v.er  = er[7:0];
    v.eo  = eo[0];
    v.ec  = ec[2:0];
    v.ed  = ed[7:0];
    v.eov = eov[7:0];
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int iv, input int ir, input int io, input int rdy, input int clr);
    bus_if.in_valid    = iv[0];
    bus_if.in_result   = ir[7:0];
    bus_if.in_overflow = io[0];
    bus_if.out_ready   = rdy[0];
    clear              = clr[0];
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[18];

  initial begin
    int k;
    int n_in;
    logic       prev_stall;
    logic [7:0] prev_res;

    checks   = 0;
    failures = 0;

    // in_valid, in_result, in_ovf, ready, clear | exp valid, result, ovf, count, drops, ovfs
    vecs[0]  = mk(1, 8'h08, 0, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    vecs[1]  = mk(1, 8'h03, 0, 1, 0,  1, 8'h08, 0, 1, 0, 0);
    vecs[2]  = mk(0, 8'h00, 0, 1, 0,  1, 8'h03, 0, 1, 0, 0);
    vecs[3]  = mk(1, 8'h80, 1, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    vecs[4]  = mk(1, 8'hFF, 0, 1, 0,  1, 8'h80, 1, 1, 0, 1);
    vecs[5]  = mk(0, 8'h00, 0, 1, 0,  1, 8'hFF, 0, 1, 0, 1);
    vecs[6]  = mk(1, 8'h01, 0, 0, 0,  0, 8'h00, 0, 0, 0, 1);
    vecs[7]  = mk(1, 8'h02, 0, 0, 0,  1, 8'h01, 0, 1, 0, 1);
    vecs[8]  = mk(1, 8'h03, 0, 0, 0,  1, 8'h01, 0, 2, 0, 1);
    vecs[9]  = mk(1, 8'h04, 0, 0, 0,  1, 8'h01, 0, 3, 0, 1);
    vecs[10] = mk(1, 8'h05, 0, 0, 0,  1, 8'h01, 0, 4, 0, 1);
    // Dropped overflow result must not bump the overflow counter.
    vecs[11] = mk(1, 8'h06, 1, 0, 0,  1, 8'h01, 0, 4, 1, 1);
    // Full with a same-cycle pop: 9 is accepted.
    vecs[12] = mk(1, 8'h09, 0, 1, 0,  1, 8'h01, 0, 4, 2, 1);
    vecs[13] = mk(0, 8'h00, 0, 1, 0,  1, 8'h02, 0, 4, 2, 1);
    vecs[14] = mk(0, 8'h00, 0, 1, 0,  1, 8'h03, 0, 3, 2, 1);
    vecs[15] = mk(0, 8'h00, 0, 1, 0,  1, 8'h04, 0, 2, 2, 1);
    vecs[16] = mk(0, 8'h00, 0, 1, 0,  1, 8'h09, 0, 1, 2, 1);
    vecs[17] = mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 2, 1);

    // Reset state
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    check("rst out_valid", int'(bus_if.out_valid), 0);
    check("rst out_result", int'(bus_if.out_result), 0);
    check("rst out_overflow", int'(bus_if.out_overflow), 0);
    check("rst count", int'(count), 0);
    check("rst empty", int'(empty), 1);
    check("rst full", int'(full), 0);
    check("rst drop_count", int'(drop_count), 0);
    check("rst ovf_count", int'(ovf_count), 0);
    step();
    rst_n = 1'b1;

    // Table-driven section: outputs are checked before the edge that consumes the inputs.
    for (int i = 0; i < 18; i++) begin
      drive(int'(vecs[i].iv), int'(vecs[i].ir), int'(vecs[i].io), int'(vecs[i].rdy),
            int'(vecs[i].clr));
      #3;
      check($sformatf("v%0d out_valid", i), int'(bus_if.out_valid), int'(vecs[i].ev));
      check($sformatf("v%0d count", i), int'(count), int'(vecs[i].ec));
      check($sformatf("v%0d full", i), int'(full), int'(vecs[i].ec == 3'd4));
      check($sformatf("v%0d empty", i), int'(empty), int'(vecs[i].ec == 3'd0));
      check($sformatf("v%0d drop_count", i), int'(drop_count), int'(vecs[i].ed));
      check($sformatf("v%0d ovf_count", i), int'(ovf_count), int'(vecs[i].eov));
      if (vecs[i].ev) begin
        check($sformatf("v%0d out_result", i), int'(bus_if.out_result), int'(vecs[i].er));
        check($sformatf("v%0d out_overflow", i), int'(bus_if.out_overflow), int'(vecs[i].eo));
      end
      step();
    end

    // Pointer wrap and stall: push 10 values (0x20..0x29) two cycles in three, ready toggles.
    k          = 0;
    n_in       = 0;
    prev_stall = 1'b0;
    prev_res   = 8'h00;
    for (int c = 0; c < 60; c++) begin
      if ((n_in < 10) && (c % 3 != 2)) begin
        drive(1, 32 + n_in, 0, c % 2, 0);
        n_in++;
      end else begin
        drive(0, 0, 0, c % 2, 0);
      end
      #3;
      if (prev_stall) check("stall hold", int'(bus_if.out_result), int'(prev_res));
      if (bus_if.out_valid && bus_if.out_ready) begin
        check("stream order", int'(bus_if.out_result), 32 + k);
        k++;
      end
      prev_stall = bus_if.out_valid && !bus_if.out_ready;
      prev_res   = bus_if.out_result;
      step();
    end
    check("stream received", k, 10);
    check("stream drops", int'(drop_count), 2);
    check("stream empty", int'(empty), 1);

    // Clear in the same cycle as a drop.
    for (int i = 0; i < 4; i++) begin
      drive(1, 64 + i, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    #3;
    check("pre-clear drop_count", int'(drop_count), 2);
    check("pre-clear full", int'(full), 1);
    step();
    drive(1, 8'h77, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    #3;
    check("clear drop_count", int'(drop_count), 0);
    check("clear ovf_count", int'(ovf_count), 0);
    check("clear keeps count", int'(count), 4);
    check("clear keeps head", int'(bus_if.out_result), 64);
    step();
    drive(1, 8'h78, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 0);
    #3;
    check("drop after clear", int'(drop_count), 1);
    step();
    drive(0, 0, 0, 0, 0);
    #1;
    check("pre-reset count", int'(count), 3);
    check("pre-reset head", int'(bus_if.out_result), 65);

    // Asynchronous reset with 3 entries queued: effect is immediate.
    rst_n = 1'b0;
    #1;
    check("async rst count", int'(count), 0);
    check("async rst out_valid", int'(bus_if.out_valid), 0);
    check("async rst out_result", int'(bus_if.out_result), 0);
    check("async rst drop_count", int'(drop_count), 0);
    step();
    rst_n = 1'b1;
    step();
    check("post-rst out_valid", int'(bus_if.out_valid), 0);

    // Saturation of both counters.
    for (int i = 0; i < 4; i++) begin
      drive(1, 100 + i, 1, 0, 0);
      step();
    end
    drive(1, 8'h55, 1, 0, 0);
    for (int i = 0; i < 300; i++) step();
    drive(0, 0, 0, 0, 0);
    #3;
    check("sat drop_count", int'(drop_count), 255);
    check("sat ovf_count", int'(ovf_count), 4);
    check("sat head", int'(bus_if.out_result), 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
